// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver FSM encoding, default 50 MHz line timing
// (common with the transmit-side controller) and frame geometry.
package ws2812_pkg;

  typedef enum logic [2:0] {
    SYNC,
    ARMED,
    HIGH,
    LOW,
    ERR
  } rx_state_t;

  localparam int unsigned T0H_CYC     = 20;
  localparam int unsigned T1H_CYC     = 40;
  localparam int unsigned T0L_CYC     = 42;
  localparam int unsigned T1L_CYC     = 22;
  localparam int unsigned RST_CYC_DEF = 2500;

  localparam int unsigned WORD_W  = 24;
  localparam int unsigned MAX_PIX = 64;

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Synchronises the raw WS2812 line, flags edges of the synchronised level and
// counts cycles since the last edge (saturating).
module ws2812_pulse_meas
  import ws2812_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] width
);

  logic meta;
  logic din_s;
  logic din_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      din_s <= 1'b0;
      din_q <= 1'b0;
      width <= '0;
    end else begin
      meta  <= din;
      din_s <= meta;
      din_q <= din_s;
      if (din_s != din_q)
        width <= '0;
      else if (width != '1)
        width <= width + CNT_W'(1);
    end
  end

  assign level = din_s;
  assign rise  = din_s & ~din_q;
  assign fall  = ~din_s & din_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receive decoder: classifies high pulses into bits, assembles 24-bit
// GRB words with a per-frame index and reports frame end on the reset gap.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned T1_MIN_CYC   = 30,
  parameter int unsigned HIGH_MIN_CYC = 8,
  parameter int unsigned HIGH_MAX_CYC = 60,
  parameter int unsigned RST_CYC      = RST_CYC_DEF,
  parameter int unsigned CNT_W        = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              din,
  output logic              pix_valid,
  output logic [WORD_W-1:0] pix_data,
  output logic [5:0]        pix_num,
  output logic              frame_done,
  output logic [6:0]        frame_len,
  output logic              bit_err,
  output logic              ovf
);

  localparam logic [CNT_W:0]   T1_MIN_W   = (CNT_W+1)'(T1_MIN_CYC);
  localparam logic [CNT_W:0]   HIGH_MIN_W = (CNT_W+1)'(HIGH_MIN_CYC);
  localparam logic [CNT_W:0]   RST_W      = (CNT_W+1)'(RST_CYC);
  localparam logic [CNT_W-1:0] HIGH_MAX_C = CNT_W'(HIGH_MAX_CYC);
  localparam logic [4:0]       LAST_BIT   = 5'(WORD_W - 1);
  localparam logic [6:0]       PIX_LIMIT  = 7'(MAX_PIX);

  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] width;
  logic [CNT_W:0]   w_ext;
  logic             gap;
  logic             bit_val;

  rx_state_t state;
  rx_state_t state_next;
  logic      shift_en;
  logic      err_now;
  logic      gap_end;
  logic      clear_frame;

  logic [WORD_W-2:0] shreg;
  logic [4:0]        bit_cnt;
  logic [6:0]        wcnt;

  ws2812_pulse_meas #(
    .CNT_W(CNT_W)
  ) u_meas (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .din  (din),
    .level(level),
    .rise (rise),
    .fall (fall),
    .width(width)
  );

  // width counts completed cycles since the last edge, so the pulse/gap length is width+1
  assign w_ext   = {1'b0, width} + (CNT_W+1)'(1);
  assign bit_val = (w_ext >= T1_MIN_W);
  assign gap     = !level && !rise && !fall && (w_ext >= RST_W);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= SYNC;
    else            state <= state_next;
  end

  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    err_now     = 1'b0;
    gap_end     = 1'b0;
    clear_frame = 1'b0;
    case (state)
      SYNC, ERR: begin
        if (gap) begin
          state_next  = ARMED;
          clear_frame = 1'b1;
        end
      end
      ARMED: begin
        if (rise) state_next = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if (w_ext < HIGH_MIN_W) begin
            err_now    = 1'b1;
            state_next = ERR;
          end else begin
            shift_en   = 1'b1;
            state_next = LOW;
          end
        end else if (width > HIGH_MAX_C) begin
          err_now    = 1'b1;
          state_next = ERR;
        end
      end
      LOW: begin
        if (rise) begin
          state_next = HIGH;
        end else if (gap) begin
          gap_end    = 1'b1;
          state_next = ARMED;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_num    <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      bit_err    <= 1'b0;
      ovf        <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      wcnt       <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      bit_err    <= 1'b0;
      if (shift_en) begin
        shreg <= {shreg[WORD_W-3:0], bit_val};
        if (bit_cnt == LAST_BIT) begin
          pix_valid <= 1'b1;
          pix_data  <= {shreg, bit_val};
          pix_num   <= wcnt[5:0];
          bit_cnt   <= '0;
          if (wcnt != '1)        wcnt <= wcnt + 7'd1;
          if (wcnt >= PIX_LIMIT) ovf  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (err_now) begin
        bit_err <= 1'b1;
        bit_cnt <= '0;
        shreg   <= '0;
      end
      if (gap_end) begin
        bit_cnt <= '0;
        wcnt    <= '0;
        if (bit_cnt != '0) bit_err <= 1'b1;
        if (wcnt != '0) begin
          frame_done <= 1'b1;
          frame_len  <= (wcnt > PIX_LIMIT) ? PIX_LIMIT : wcnt;
          ovf        <= 1'b0;
        end
      end
      if (clear_frame) begin
        bit_cnt <= '0;
        wcnt    <= '0;
        shreg   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: scoreboard of expected words and frame
// lengths, consumed as the decoder reports them.
module tb_ws2812_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        din;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [5:0]  pix_num;
  logic        frame_done;
  logic [6:0]  frame_len;
  logic        bit_err;
  logic        ovf;

  always #10 sys_clk = ~sys_clk;

  ws2812_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (din),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_num   (pix_num),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .bit_err   (bit_err),
    .ovf       (ovf)
  );

  typedef struct {
    logic [23:0] data;
    logic [5:0]  num;
    logic        ovf;
  } pix_t;

  pix_t pix_q[$];
  int   len_q[$];
  pix_t mon_e;

  int checks   = 0;
  int errors   = 0;
  int err_seen = 0;
  int err_base = 0;

  int t1h = 40;
  int t1l = 22;
  int t0h = 20;
  int t0l = 42;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b);
    din = 1'b1;
    tick(b ? t1h : t0h);
    din = 1'b0;
    tick(b ? t1l : t0l);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic expect_pix(input logic [23:0] w, input int num, input logic o);
    pix_t e;
    e.data = w;
    e.num  = 6'(num);
    e.ovf  = o;
    pix_q.push_back(e);
  endtask

  task automatic phase_end(input string tag, input int err_exp);
    check({tag, "_pix_left"}, 32'(pix_q.size()), 0);
    check({tag, "_frame_left"}, 32'(len_q.size()), 0);
    check({tag, "_bit_err"}, 32'(err_seen - err_base), 32'(err_exp));
    pix_q.delete();
    len_q.delete();
    err_base = err_seen;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check({tag, "_pix_data"}, 32'(pix_data), 0);
    check({tag, "_pix_num"}, 32'(pix_num), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_frame_len"}, 32'(frame_len), 0);
    check({tag, "_bit_err"}, 32'(bit_err), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  always @(negedge sys_clk) begin
    if (pix_valid) begin
      if (pix_q.size() == 0) begin
        check("pix_unexpected", 32'(pix_valid), 0);
      end else begin
        mon_e = pix_q.pop_front();
        check("pix_data", 32'(pix_data), 32'(mon_e.data));
        check("pix_num", 32'(pix_num), 32'(mon_e.num));
        check("pix_ovf", 32'(ovf), 32'(mon_e.ovf));
      end
    end
    if (frame_done) begin
      if (len_q.size() == 0) check("frame_unexpected", 32'(frame_done), 0);
      else                   check("frame_len", 32'(frame_len), 32'(len_q.pop_front()));
    end
    if (bit_err) err_seen++;
  end

  initial begin
    sys_rst_n = 1'b0;
    din       = 1'b0;
    tick(4);
    check_zero_outputs("reset");
    sys_rst_n = 1'b1;

    // single word after a clean gap
    tick(3000);
    expect_pix(24'hFF0055, 0, 1'b0);
    send_word(24'hFF0055);
    len_q.push_back(1);
    tick(2600);
    phase_end("single", 0);

    // join mid-word: nothing decoded until the first reset gap
    sys_rst_n = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    din = 1'b1;
    tick(15);
    din = 1'b0;
    tick(22);
    for (int i = 0; i < 20; i++) send_bit(logic'((i % 3) == 0));
    tick(2600);
    expect_pix(24'h123456, 0, 1'b0);
    send_word(24'h123456);
    len_q.push_back(1);
    tick(2600);
    phase_end("midword", 0);

    // three back-to-back words
    expect_pix(24'h000001, 0, 1'b0);
    expect_pix(24'h800000, 1, 1'b0);
    expect_pix(24'hAAAAAA, 2, 1'b0);
    send_word(24'h000001);
    send_word(24'h800000);
    send_word(24'hAAAAAA);
    len_q.push_back(3);
    tick(2600);
    phase_end("three", 0);

    // 66 words at the classification boundaries (1 = exactly 30, 0 = exactly 8)
    t1h = 30; t1l = 4; t0h = 8; t0l = 4;
    for (int i = 0; i < 66; i++) begin
      expect_pix(24'h0F0F0F, i % 64, logic'(i >= 64));
      send_word(24'h0F0F0F);
    end
    len_q.push_back(64);
    tick(2600);
    check("ovf_cleared", 32'(ovf), 0);
    phase_end("overflow", 0);

    // short glitch: error, following word ignored until a gap
    din = 1'b1;
    tick(5);
    din = 1'b0;
    tick(50);
    send_word(24'hC3A5F0);
    tick(2600);
    expect_pix(24'h5A5A5A, 0, 1'b0);
    send_word(24'h5A5A5A);
    len_q.push_back(1);
    tick(2600);
    phase_end("glitch", 1);

    // over-long high pulse
    din = 1'b1;
    tick(80);
    din = 1'b0;
    tick(2600);
    expect_pix(24'h3C0FF1, 0, 1'b0);
    send_word(24'h3C0FF1);
    len_q.push_back(1);
    tick(2600);
    phase_end("longhigh", 1);

    // partial word ended by the gap
    for (int i = 0; i < 10; i++) send_bit(logic'(i & 1));
    tick(2600);
    phase_end("partial", 1);

    // reset in the middle of a word
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    din = 1'b1;
    tick(10);
    sys_rst_n = 1'b0;
    tick(1);
    check_zero_outputs("midreset");
    sys_rst_n = 1'b1;
    din = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- One-wire WS2812 stream decoder, the receive-side counterpart of the LED transmit path.
- Samples a led_data-style line, classifies each bit by its high-pulse width, and assembles 24-bit GRB words.
- Emits each word with a pixel index and marks frame end on the reset gap.
- Used for loopback checking of the strip driver on-board and for sniffing daisy-chained strips.

Parameters:
- T1_MIN_CYC, 30, minimum high width in sys_clk cycles classified as logic 1 (T0H≈20, T1H≈40 at 50 MHz).
- HIGH_MIN_CYC, 8, high pulses shorter than this are glitches (error).
- HIGH_MAX_CYC, 60, high pulses longer than this are errors.
- RST_CYC, 2500, low time marking a frame reset (50 µs at 50 MHz).
- CNT_W, 12, width of the pulse-width counter (must hold RST_CYC).

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  synchronous, active-low reset
- din  in  1  asynchronous WS2812 serial input
- pix_valid  out  1  one-cycle strobe: pix_data/pix_num valid
- pix_data  out  24  received word, first bit at [23] (G[7:0],R[7:0],B[7:0])
- pix_num  out  6  index of the word within the current frame, 0-based
- frame_done  out  1  one-cycle strobe at reset-gap detection after ≥1 complete word
- frame_len  out  7  number of complete words in the frame just ended, valid with frame_done
- bit_err  out  1  one-cycle strobe on a framing/timing error
- ovf  out  1  sticky: more than 64 words in the current frame; cleared on frame_done

Behaviour:
- Reset is synchronous, active-low (sys_rst_n sampled on sys_clk rising edge). On reset:
  - all outputs = 0, pix_data = 0, pix_num = 0, frame_len = 0;
  - FSM enters SYNC; synchronizer flops = 0.
- din passes a 2-flop synchronizer (din_s); edges are detected on din_s versus its previous value. All latencies below count from the cycle din_s changes.
- Counter cnt: cleared on each din_s edge, otherwise increments, saturating at all-ones.
- FSM:
  - SYNC: wait for din_s low for RST_CYC consecutive cycles, then go to ARMED. A rising edge restarts the count. No words are accepted before the first reset gap.
  - ARMED: line low, no bits yet in this frame; rising edge goes to HIGH.
  - HIGH: on falling edge, classify w = cnt+1:
    - w < HIGH_MIN_CYC → bit_err, go to ERR;
    - w ≥ T1_MIN_CYC → bit 1, else bit 0; shift into the shift register; bit_cnt++; go to LOW.
    - If cnt exceeds HIGH_MAX_CYC while high → bit_err, go to ERR.
  - LOW:
    - Rising edge → HIGH.
    - Low count reaching RST_CYC → frame end:
      - if bit_cnt ≠ 0 (partial word) → bit_err, word discarded;
      - if ≥1 word in the frame → frame_done pulse with frame_len;
      - go to ARMED; clear word counter and bit_cnt.
  - ERR: discard shift register and bit_cnt; behave like SYNC (need RST_CYC low). On exit, the word counter is cleared without frame_done.
- Word completion: on the classifying falling edge where bit_cnt reaches 24, next cycle:
  - pix_valid = 1; pix_data = assembled word; pix_num = word counter;
  - word counter increments; bit_cnt = 0.
  - pix_data/pix_num hold until the next pix_valid.
- Word counter is 7 bits:
  - pix_num = counter[5:0], so it wraps 63 → 0;
  - at the 65th word ovf is set, and stays set until frame_done or reset;
  - frame_len saturates at 64 once ovf is set.
- Simultaneous events:
  - reset gap and rising edge in the same cycle: the edge wins and the gap is not declared;
  - pix_valid and frame_done cannot coincide, because frame end needs RST_CYC low after the last edge.
- Reset mid-frame: all state discarded; a fresh SYNC gap is required.

Decomposition:
- Shared package ws2812_pkg:
  - FSM state encoding (SYNC, ARMED, HIGH, LOW, ERR);
  - default timing constants (T0H/T1H/T0L/T1L/RST in cycles at 50 MHz), shared with the transmit-side controller;
  - word width 24 and max pixel count 64.
- One natural sub-module, ws2812_pulse_meas: synchronizer, edge detect and width counter, with outputs rise, fall and width.

Test Plan:
- 3000 cycles low, then one word 0xFF0055 (1-bits high 40/low 22, 0-bits high 20/low 42), then 2600 low → pix_valid once with pix_data=0xFF0055, pix_num=0; then frame_done with frame_len=1; bit_err never asserts.
- Stimulus starts mid-word with no prior gap → no pix_valid until after the first 2500-cycle low; the following word 0x123456 is decoded correctly.
- 3 words 0x000001, 0x800000, 0xAAAAAA back-to-back → pix_num 0,1,2 with matching data; frame_done, frame_len=3.
- 66 words of 0x0F0F0F → pix_num wraps to 0 on the 65th word, ovf=1 from the 65th pix_valid; frame_done with frame_len=64, after which ovf=0.
- A 5-cycle high glitch, and separately an 80-cycle high → bit_err pulse, no pix_valid; decoding resumes correctly only after a 2500-cycle low.
- 10 bits followed by a 2600-cycle gap → bit_err, no pix_valid, no frame_done. Assert sys_rst_n=0 mid-word → all outputs 0 on the next clock.
